// File: rtl/frame_reader_if.sv
// Pixel stream, SRAM read bus and control for frame_reader, bundled in one interface.
// The master side is the reader. The slave side is the SRAM and display environment.
interface frame_reader_if;
    logic        start;
    logic        sel_dehazed;
    logic [15:0] SRAM_DATA;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_WRITE;
    logic [23:0] o_pixel;
    logic        o_valid;
    logic        i_ready;
    logic        o_sof;
    logic        o_eol;
    logic        o_finish;
    logic [1:0]  state;

    // Stream handshake: a pixel transfers on a rising edge where o_valid && i_ready.
    // o_pixel, o_sof and o_eol stay stable while o_valid && !i_ready.
    modport master (
        input  start, sel_dehazed, SRAM_DATA, i_ready,
        output SRAM_ADDR, SRAM_WRITE, o_pixel, o_valid, o_sof, o_eol, o_finish, state
    );

    modport slave (
        output start, sel_dehazed, SRAM_DATA, i_ready,
        input  SRAM_ADDR, SRAM_WRITE, o_pixel, o_valid, o_sof, o_eol, o_finish, state
    );
endinterface

// File: rtl/frame_reader.sv
// Streams a stored frame out of SRAM as raster-order 24-bit RGB pixels.
// Each pixel takes three consecutive word reads, one per channel, then waits for the handshake.
module frame_reader #(
    parameter int BASE_ADDR = 0,
    parameter int H_PIXEL   = 320,
    parameter int V_PIXEL   = 480
) (
    input  logic           clk,
    input  logic           rst,
    frame_reader_if.master bus
);
    localparam int CW = $clog2(H_PIXEL + 1);
    localparam int RW = $clog2(V_PIXEL + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [19:0]   BASE     = 20'(BASE_ADDR);
    localparam logic [CW-1:0] COL_LAST = CW'(H_PIXEL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_PIXEL - 1);

    logic [1:0]    state;
    logic [1:0]    ch;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          sel;
    logic [7:0]    r_byte;
    logic [7:0]    g_byte;
    logic [7:0]    data_byte;
    logic [19:0]   addr;
    logic [23:0]   pixel;
    logic          valid;
    logic          sof;
    logic          eol;
    logic          finish;

    assign data_byte      = sel ? bus.SRAM_DATA[15:8] : bus.SRAM_DATA[7:0];
    assign bus.SRAM_WRITE = 1'b0;
    assign bus.SRAM_ADDR  = addr;
    assign bus.o_pixel    = pixel;
    assign bus.o_valid    = valid;
    assign bus.o_sof      = sof;
    assign bus.o_eol      = eol;
    assign bus.o_finish   = finish;
    assign bus.state      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ch     <= 2'd0;
            col    <= '0;
            row    <= '0;
            sel    <= 1'b0;
            r_byte <= 8'd0;
            g_byte <= 8'd0;
            addr   <= BASE;
            pixel  <= 24'd0;
            valid  <= 1'b0;
            sof    <= 1'b0;
            eol    <= 1'b0;
            finish <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FINISH: begin
                    if (bus.start) begin
                        sel    <= bus.sel_dehazed;
                        addr   <= BASE;
                        ch     <= 2'd0;
                        col    <= '0;
                        row    <= '0;
                        finish <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // SRAM data belongs to the address driven this cycle.
                    addr <= addr + 20'd1;
                    case (ch)
                        2'd0: begin
                            r_byte <= data_byte;
                            ch     <= 2'd1;
                        end
                        2'd1: begin
                            g_byte <= data_byte;
                            ch     <= 2'd2;
                        end
                        default: begin
                            pixel <= {r_byte, g_byte, data_byte};
                            valid <= 1'b1;
                            sof   <= (row == '0) && (col == '0);
                            eol   <= (col == COL_LAST);
                            ch    <= 2'd0;
                            state <= S_OUT;
                        end
                    endcase
                end
                S_OUT: begin
                    if (bus.i_ready) begin
                        valid <= 1'b0;
                        sof   <= 1'b0;
                        eol   <= 1'b0;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                            if (row == ROW_LAST) begin
                                finish <= 1'b1;
                                state  <= S_FINISH;
                            end else begin
                                state <= S_FETCH;
                            end
                        end else begin
                            col   <= col + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader on a reduced 8x6 frame with an address-derived SRAM model.
module tb_frame_reader;
  localparam int BASE = 0;
  localparam int H    = 8;
  localparam int V    = 6;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_reader_if bus();

  frame_reader #(.BASE_ADDR(BASE), .H_PIXEL(H), .V_PIXEL(V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: word[a] = {~a[7:0], a[7:0]}
  assign bus.SRAM_DATA = {~bus.SRAM_ADDR[7:0], bus.SRAM_ADDR[7:0]};

  int n_vec = 0;
  int n_err = 0;
  logic [25:0] exp_q[$];

  int   ready_mode = 0;
  int   acc_cnt, eol_cnt, sof_cnt, stall_cnt;
  logic stalled = 1'b0;
  logic wrote = 1'b0;
  logic [23:0] hold_px;
  logic [19:0] hold_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan(input int a, input logic s);
    logic [19:0] av;
    av = 20'(a);
    return s ? ~av[7:0] : av[7:0];
  endfunction

  task automatic push_frame(input logic s);
    int a;
    for (int p = 0; p < NPIX; p++) begin
      a = BASE + 3 * p;
      exp_q.push_back({(p == 0), ((p % H) == H - 1), chan(a, s), chan(a + 1, s), chan(a + 2, s)});
    end
  endtask

  // Monitor and ready driver: ready is chosen at the falling edge, so a valid&&ready
  // seen here is the transfer happening on the next rising edge.
  always @(negedge clk) begin
    logic [25:0] e;
    if (bus.SRAM_WRITE !== 1'b0) wrote = 1'b1;
    if (rst) begin
      stalled = 1'b0;
      bus.i_ready = 1'b0;
    end else begin
      if (stalled && bus.o_valid) begin
        check("hold_pixel", 32'(bus.o_pixel), 32'(hold_px));
        check("hold_addr", 32'(bus.SRAM_ADDR), 32'(hold_addr));
        stall_cnt++;
      end
      case (ready_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b0;
      endcase
      stalled   = bus.o_valid && !bus.i_ready;
      hold_px   = bus.o_pixel;
      hold_addr = bus.SRAM_ADDR;
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_pixel", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {6'd0, bus.o_sof, bus.o_eol, bus.o_pixel}, {6'd0, e});
          acc_cnt++;
          if (bus.o_eol) eol_cnt++;
          if (bus.o_sof) sof_cnt++;
        end
      end
    end
  end

  task automatic start_frame(input logic s, output int lat);
    push_frame(s);
    acc_cnt = 0; eol_cnt = 0; sof_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.sel_dehazed = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    @(negedge clk);
    check("finish_drop", 32'(bus.o_finish), 32'd0);
    while (!bus.o_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic wait_acc(input int n);
    int budget;
    budget = 0;
    while (acc_cnt < n && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    check("wait_acc_timeout", 32'(acc_cnt >= n), 32'd1);
  endtask

  task automatic frame_done(input string tag);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!bus.o_finish && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_finish"}, 32'(bus.o_finish), 32'd1);
    check({tag, "_accepted"}, 32'(acc_cnt), 32'(NPIX));
    check({tag, "_eol_count"}, 32'(eol_cnt), 32'(V));
    check({tag, "_sof_count"}, 32'(sof_cnt), 32'd1);
    check({tag, "_valid_low"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_end_addr"}, 32'(bus.SRAM_ADDR), 32'(BASE + 3 * NPIX));
    check({tag, "_state"}, 32'(bus.state), 32'd3);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.sel_dehazed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_addr", 32'(bus.SRAM_ADDR), 32'(BASE));
    check("rst_pixel", 32'(bus.o_pixel), 32'd0);
    check("rst_sof", 32'(bus.o_sof), 32'd0);
    check("rst_eol", 32'(bus.o_eol), 32'd0);
    check("rst_finish", 32'(bus.o_finish), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);

    // Frame A: original bytes, always ready, stray start and sel change mid-frame
    ready_mode = 0;
    start_frame(1'b0, lat);
    check("latency", 32'(lat), 32'd4);
    wait_acc(H + 2);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.sel_dehazed = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    frame_done("frame_a");

    // Frame B: restart from FINISH with dehazed bytes, random ready plus a long stall
    ready_mode = 1;
    start_frame(1'b1, lat);
    wait_acc(5);
    @(posedge clk); #1;
    ready_mode = 2;
    stall_cnt = 0;
    repeat (30) begin
      if (!bus.o_valid) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    #1 ready_mode = 1;
    check("stall_seen", 32'(stall_cnt >= 9), 32'd1);
    frame_done("frame_b");

    // Frame C: abandoned by a reset mid-frame
    start_frame(1'b0, lat);
    wait_acc(NPIX / 2);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.o_valid), 32'd0);
    check("midrst_addr", 32'(bus.SRAM_ADDR), 32'(BASE));
    check("midrst_finish", 32'(bus.o_finish), 32'd0);
    check("midrst_state", 32'(bus.state), 32'd0);
    repeat (20) @(posedge clk);

    // Frame D: fresh start after the reset, random ready
    start_frame(1'b0, lat);
    check("latency_after_rst", 32'(lat), 32'd4);
    frame_done("frame_d");

    check("sram_write_never", 32'(wrote), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
